// File: rtl/multdiv_iter_unit.sv
// Iterative radix-2 multiply/divide unit with valid/ready handshakes, kill and overflow reporting.
// Optional MULTDIV_EARLY_OUT_EN: zero-operand operations finish at the accept edge.
module multdiv_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] MIN_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               is_uns_q, is_uns_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   amag, bmag;
    logic [WIDTH:0]     mul_sum, trial;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt;
    logic [WIDTH-1:0]   res_mag, res_s;
    logic               mul_ovf, div_ovf;

    always_comb begin
        sa   = ~op[1] & operand_a[WIDTH-1];
        sb   = ~op[1] & operand_b[WIDTH-1];
        amag = sa ? -operand_a : operand_a;
        bmag = sb ? -operand_b : operand_b;

        // Multiply: conditional add into the upper half, then shift the whole register right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: remainder in the upper half, dividend shifts out / quotient shifts in below.
        trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
        div_nxt = {(trial[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~trial[WIDTH]};
        acc_nxt = is_div_q ? div_nxt : mul_nxt;

        res_mag = acc_nxt[WIDTH-1:0];
        res_s   = neg_q ? -res_mag : res_mag;
        // Signed magnitude 2^(WIDTH-1) is representable only when the result is negative.
        mul_ovf = is_uns_q ? |acc_nxt[2*WIDTH-1:WIDTH]
                           : (|acc_nxt[2*WIDTH-1:WIDTH-1]) & ~(neg_q & (acc_nxt == MIN_MAG));
        div_ovf = ~is_uns_q & ~neg_q & res_mag[WIDTH-1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_uns_d = is_uns_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    is_div_d = op[0];
                    is_uns_d = op[1];
                    neg_d    = sa ^ sb;
                    opb_d    = op[0] ? bmag : amag;
                    acc_d    = {{WIDTH{1'b0}}, (op[0] ? amag : bmag)};
                    cnt_d    = '0;
                    state_d  = BUSY;
`ifdef MULTDIV_EARLY_OUT_EN
                    if (operand_a == '0 || operand_b == '0) begin
                        result_d = '0;
                        exc_d    = op[0] & (operand_b == '0);
                        state_d  = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        if (is_div_q && opb_q == '0) begin
                            result_d = '0;
                            exc_d    = 1'b1;
                        end else begin
                            result_d = res_s;
                            exc_d    = is_div_q ? div_ovf : mul_ovf;
                        end
                    end
                end
            end
            DONE: begin
                if (kill || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_uns_q <= 1'b0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_uns_q <= is_uns_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Directed bench for multdiv_iter_unit at WIDTH = 32; latency of zero-operand cases depends on MULTDIV_EARLY_OUT_EN.
module tb_multdiv_iter_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, kill, out_valid, out_ready, exception;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, result;
    int          checks = 0;
    int          errors = 0;

`ifdef MULTDIV_EARLY_OUT_EN
    localparam int EL = 0;
`else
    localparam int EL = 32;
`endif

    multdiv_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .exception(exception)
    );

    always #5 clock = ~clock;

    // Issues one op, returns edges from accept to out_valid, the result, and whether in_ready was seen while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic exc, output logic rdy_seen);
        in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        in_valid = 1'b0; operand_a = 32'h5A5A5A5A; operand_b = 32'hA5A5A5A5; op = 2'b10;
        lat = 0; rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy_seen |= in_ready;
            @(posedge clock); #1;
            lat++;
        end
        res = result; exc = exception;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0;
        #23;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (exception !== 1'b0) begin errors++; $display("FAIL reset_exception: got %b want 0", exception); end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mul();
        logic [1:0]  o[6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [31:0] a[6] = '{32'd7, 32'h00010000, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'd0};
        logic [31:0] b[6] = '{32'hFFFFFFFD, 32'h00010000, 32'd2, 32'hFFFF8000, 32'd1, 32'hFFFFFFF9};
        logic [31:0] r[6] = '{32'hFFFFFFEB, 32'h0, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h0};
        logic        e[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          l[6] = '{32, 32, 32, 32, 32, EL};
        int lat; logic [31:0] res; logic exc, rdy;
        for (int i = 0; i < 6; i++) begin
            run_op(o[i], a[i], b[i], lat, res, exc, rdy);
            checks++; if (res !== r[i]) begin errors++; $display("FAIL mul%0d_result: got %h want %h", i, res, r[i]); end
            checks++; if (exc !== e[i]) begin errors++; $display("FAIL mul%0d_exception: got %b want %b", i, exc, e[i]); end
            checks++; if (lat != l[i]) begin errors++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, l[i]); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mul%0d_in_ready_busy: got %b want 0", i, rdy); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  o[6] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
        logic [31:0] a[6] = '{32'd100, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'd5, 32'd0};
        logic [31:0] b[6] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
        logic [31:0] r[6] = '{32'hFFFFFFF2, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'h0, 32'h0};
        logic        e[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int          l[6] = '{32, 32, 32, 32, EL, EL};
        int lat; logic [31:0] res; logic exc, rdy;
        for (int i = 0; i < 6; i++) begin
            run_op(o[i], a[i], b[i], lat, res, exc, rdy);
            checks++; if (res !== r[i]) begin errors++; $display("FAIL div%0d_result: got %h want %h", i, res, r[i]); end
            checks++; if (exc !== e[i]) begin errors++; $display("FAIL div%0d_exception: got %b want %b", i, exc, e[i]); end
            checks++; if (lat != l[i]) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, l[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        in_valid = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
        @(posedge clock); #1;
        in_valid = 1'b0; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF;
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL bp_latency: got %0d want 32", n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b1 || result !== 32'd12) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b result=%h want valid=1 result=0000000c", i, out_valid, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_kill();
        logic seen = 1'b0;
        int n = 0;
        in_valid = 1'b1; op = 2'b01; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_busy_ready: got %b want 1", in_ready); end
        repeat (40) begin @(posedge clock); #1; seen |= out_valid; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_busy_no_result: got %b want 0", seen); end
        // kill in IDLE wins over in_valid
        in_valid = 1'b1; kill = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd2;
        @(posedge clock); #1;
        in_valid = 1'b0; kill = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_idle_block: got in_ready=%b want 1", in_ready); end
        // kill while DONE drops the result
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL kill_done_latency: got %0d want 32", n); end
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL kill_done: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        in_valid = 1'b1; op = 2'b10; operand_a = 32'd6; operand_b = 32'd7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_first: got %h want 0000002a", result); end
        // request held while DONE completes: must not be taken on the same edge
        in_valid = 1'b1; out_ready = 1'b1; op = 2'b11; operand_a = 32'd99; operand_b = 32'd9;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got in_ready=%b want 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got in_ready=%b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        checks++; if (result !== 32'd11 || n != 32) begin
            errors++; $display("FAIL b2b_second: got result=%h lat=%0d want 0000000b lat=32", result, n);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; op = 2'b00; operand_a = 32'd123; operand_b = 32'd456;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        #2 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_handshake: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        checks++; if (result !== 32'h0 || exception !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got result=%h exc=%b want 0 0", result, exception);
        end
        @(negedge clock); reset = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: got valid=%b want 0", out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_backpressure();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
